// File: rtl/run_controller_pkg.sv
// Shared encodings for run_controller: FSM states, halt-cause codes and the
// ECALL/EBREAK instruction words that stop execution.
package run_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_STOP  = 3'd1,
    CAUSE_TRAP  = 3'd2,
    CAUSE_LIMIT = 3'd3,
    CAUSE_BREAK = 3'd4
  } halt_cause_t;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  function automatic logic is_trap(input logic [31:0] insn);
    return (insn == INSN_ECALL) || (insn == INSN_EBREAK);
  endfunction

endpackage

// File: rtl/run_controller_retire_counter.sv
// Saturating retired-instruction counter; holds at all-ones, cleared only by
// the asynchronous active-low reset.
module retire_counter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] count_r;

  // Count enabled cycles, stopping at all-ones
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {COUNT_WIDTH{1'b0}};
    end else if (inc && (count_r != {COUNT_WIDTH{1'b1}})) begin
      count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/run_controller.sv
// Run/halt/single-step sequencer for the single-cycle datapath.
// Optional breakpoint support is enabled by defining RUN_BREAKPOINT_EN.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   step,
  input  logic                   stop,
  input  logic                   clearHalt,
  input  logic [COUNT_WIDTH-1:0] instrLimit,
  input  logic [XLEN-1:0]        pcCurrent,
  input  logic [31:0]            instruction,
`ifdef RUN_BREAKPOINT_EN
  input  logic                   bpValid,
  input  logic [XLEN-1:0]        bpAddress,
`endif
  output logic                   datapathEnable,
  output logic [1:0]             state,
  output logic [2:0]             haltCause,
  output logic [COUNT_WIDTH-1:0] retiredCount
);

  run_state_t             state_r, state_next_s;
  halt_cause_t            cause_r, cause_next_s, cause_s;
  logic                   trap_s, limit_s, bp_hit_s, halt_req_s, enable_s;
  logic [COUNT_WIDTH-1:0] count_s;

  assign trap_s  = is_trap(instruction);
  assign limit_s = (instrLimit != {COUNT_WIDTH{1'b0}}) && (count_s >= instrLimit);

`ifdef RUN_BREAKPOINT_EN
  logic bp_mask_r;

  // Mask the breakpoint for the first RUN cycle so a resume can leave the PC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bp_mask_r <= 1'b0;
    end else begin
      bp_mask_r <= (state_r == ST_IDLE) && start;
    end
  end

  assign bp_hit_s = bpValid && (pcCurrent == bpAddress) && (state_r == ST_RUN) && !bp_mask_r;
`else
  logic unused_pc_s;
  assign unused_pc_s = ^pcCurrent;
  assign bp_hit_s    = 1'b0;
`endif

  // Halt decode, enable gating and next-state selection
  always_comb begin
    state_next_s = state_r;
    cause_next_s = cause_r;
    halt_req_s   = stop | trap_s | limit_s | bp_hit_s;

    if (stop) begin
      cause_s = CAUSE_STOP;
    end else if (trap_s) begin
      cause_s = CAUSE_TRAP;
    end else if (limit_s) begin
      cause_s = CAUSE_LIMIT;
    end else if (bp_hit_s) begin
      cause_s = CAUSE_BREAK;
    end else begin
      cause_s = CAUSE_NONE;
    end

    enable_s = ((state_r == ST_RUN) || (state_r == ST_STEP)) && !halt_req_s;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else if (step) begin
          state_next_s = ST_STEP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_req_s) begin
          state_next_s = ST_HALTED;
          cause_next_s = cause_s;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_STEP: begin
        // A blocked step halts without executing; otherwise it retires one and idles
        if (halt_req_s) begin
          state_next_s = ST_HALTED;
          cause_next_s = cause_s;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (clearHalt) begin
          state_next_s = ST_IDLE;
          cause_next_s = CAUSE_NONE;
        end else begin
          state_next_s = ST_HALTED;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cause_next_s = CAUSE_NONE;
      end
    endcase
  end

  // State and latched halt cause
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cause_r <= CAUSE_NONE;
    end else begin
      state_r <= state_next_s;
      cause_r <= cause_next_s;
    end
  end

  retire_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_retire_counter (
    .clock (clock),
    .reset (reset),
    .inc   (enable_s),
    .count (count_s)
  );

  assign datapathEnable = enable_s;
  assign state          = state_r;
  assign haltCause      = cause_r;
  assign retiredCount   = count_s;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed scenarios followed by a
// randomized phase checked against a behavioural model.
module tb_run_controller;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, step = 1'b0, stop = 1'b0, clearHalt = 1'b0;
  logic [31:0] instrLimit = 32'd0;
  logic [31:0] pcCurrent = 32'd0;
  logic [31:0] instruction = 32'h0000_0013;
  logic        bpValid = 1'b0;
  logic [31:0] bpAddress = 32'd0;
  logic        datapathEnable;
  logic [1:0]  state;
  logic [2:0]  haltCause;
  logic [31:0] retiredCount;

  logic        s_start = 1'b0;
  logic        s_en;
  logic [1:0]  s_state;
  logic [2:0]  s_cause;
  logic [3:0]  s_count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  run_controller #(.XLEN(32), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .step(step), .stop(stop),
    .clearHalt(clearHalt), .instrLimit(instrLimit), .pcCurrent(pcCurrent),
    .instruction(instruction),
`ifdef RUN_BREAKPOINT_EN
    .bpValid(bpValid), .bpAddress(bpAddress),
`endif
    .datapathEnable(datapathEnable), .state(state), .haltCause(haltCause),
    .retiredCount(retiredCount)
  );

  run_controller #(.XLEN(32), .COUNT_WIDTH(4)) dut_sat (
    .clock(clock), .reset(reset), .start(s_start), .step(1'b0), .stop(1'b0),
    .clearHalt(1'b0), .instrLimit(4'd0), .pcCurrent(32'd0), .instruction(NOP),
`ifdef RUN_BREAKPOINT_EN
    .bpValid(1'b0), .bpAddress(32'd0),
`endif
    .datapathEnable(s_en), .state(s_state), .haltCause(s_cause),
    .retiredCount(s_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    edge1();
  endtask

  // Behavioural model state for the random phase
  int     m_state, m_cause, m_mask;
  longint m_count;

  initial begin
    int en_cnt;
    logic exp_en, trap, lim, bp, hreq;
    int hcause;

    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    edge1();
    check("reset_state", state, 2'd0);
    check("reset_count", retiredCount, 32'd0);
    check("reset_cause", haltCause, 3'd0);

    // 1: reset mid-RUN at count 7
    start = 1'b1; edge1(); start = 1'b0;
    repeat (7) edge1();
    check("t1_count7", retiredCount, 32'd7);
    check("t1_en_run", datapathEnable, 1'b1);
    reset = 1'b0;
    #1;
    check("t1_en_drop", datapathEnable, 1'b0);
    check("t1_state", state, 2'd0);
    check("t1_count", retiredCount, 32'd0);
    check("t1_cause", haltCause, 3'd0);
    reset = 1'b1;
    edge1();

    // 2: single step of a NOP
    step = 1'b1; #1;
    check("t2_idle_en", datapathEnable, 1'b0);
    edge1(); step = 1'b0; #1;
    check("t2_state_step", state, 2'd2);
    check("t2_step_en", datapathEnable, 1'b1);
    edge1(); #1;
    check("t2_state_back", state, 2'd0);
    check("t2_count", retiredCount, 32'd1);
    check("t2_en_off", datapathEnable, 1'b0);

    // 3: instruction limit of 5
    do_reset();
    instrLimit = 32'd5;
    start = 1'b1; edge1(); start = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (state == 2'd3) break;
      if (datapathEnable) en_cnt++;
      edge1();
    end
    check("t3_en_cycles", en_cnt, 5);
    check("t3_state", state, 2'd3);
    check("t3_cause", haltCause, 3'd3);
    check("t3_count", retiredCount, 32'd5);
    start = 1'b1; step = 1'b1; edge1(); start = 1'b0; step = 1'b0;
    check("t3_ignore_start", state, 2'd3);
    clearHalt = 1'b1; edge1(); clearHalt = 1'b0;
    check("t3_clr_state", state, 2'd0);
    check("t3_clr_cause", haltCause, 3'd0);
    check("t3_kept_count", retiredCount, 32'd5);
    instrLimit = 32'd0;

    // 4: ECALL on cycle 4, then stop together with ECALL
    do_reset();
    start = 1'b1; edge1(); start = 1'b0;
    repeat (3) edge1();
    instruction = ECALL; #1;
    check("t4_trap_en", datapathEnable, 1'b0);
    edge1();
    check("t4_state", state, 2'd3);
    check("t4_cause", haltCause, 3'd2);
    check("t4_count", retiredCount, 32'd3);
    clearHalt = 1'b1; edge1(); clearHalt = 1'b0;
    stop = 1'b1;
    start = 1'b1; edge1(); start = 1'b0; #1;
    check("t4_stop_en", datapathEnable, 1'b0);
    edge1();
    check("t4_stop_cause", haltCause, 3'd1);
    check("t4_stop_count", retiredCount, 32'd3);
    stop = 1'b0; instruction = EBREAK;
    clearHalt = 1'b1; edge1(); clearHalt = 1'b0;
    step = 1'b1; edge1(); step = 1'b0; #1;
    check("t4_step_trap_en", datapathEnable, 1'b0);
    edge1();
    check("t4_step_trap_cause", haltCause, 3'd2);
    instruction = NOP;

`ifdef RUN_BREAKPOINT_EN
    // 5: breakpoint at 0x10
    do_reset();
    bpValid = 1'b1; bpAddress = 32'h10; pcCurrent = 32'h0;
    start = 1'b1; edge1(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (state == 2'd3) break;
      en_cnt = datapathEnable;
      edge1();
      if (en_cnt != 0) pcCurrent = pcCurrent + 32'd4;
    end
    check("t5_state", state, 2'd3);
    check("t5_cause", haltCause, 3'd4);
    check("t5_count", retiredCount, 32'd4);
    check("t5_pc", pcCurrent, 32'h10);
    clearHalt = 1'b1; edge1(); clearHalt = 1'b0;
    start = 1'b1; edge1(); start = 1'b0; #1;
    check("t5_resume_en", datapathEnable, 1'b1);
    edge1(); pcCurrent = pcCurrent + 32'd4; #1;
    check("t5_resume_count", retiredCount, 32'd5);
    check("t5_resume_state", state, 2'd1);
    bpValid = 1'b0; pcCurrent = 32'd0;
`endif

    // Random phase against the behavioural model
    do_reset();
    m_state = 0; m_cause = 0; m_mask = 0; m_count = 0;
    bpAddress = 32'h10;
    for (int cyc = 0; cyc < 600; cyc++) begin
      start     = ($urandom_range(0, 3) == 0);
      step      = ($urandom_range(0, 5) == 0);
      clearHalt = ($urandom_range(0, 4) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 19))
        0: instruction = ECALL;
        1: instruction = EBREAK;
        default: instruction = $urandom;
      endcase
      if (m_state == 0 && $urandom_range(0, 9) == 0)
        instrLimit = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'(m_count) + $urandom_range(1, 8);
      pcCurrent = 32'(4 * $urandom_range(0, 5));
      bpValid   = $urandom_range(0, 1);
      #1;
      trap = (instruction == ECALL) || (instruction == EBREAK);
      lim  = (instrLimit != 0) && (m_count >= longint'(instrLimit));
`ifdef RUN_BREAKPOINT_EN
      bp   = bpValid && (pcCurrent == bpAddress) && (m_state == 1) && (m_mask == 0);
`else
      bp   = 1'b0;
`endif
      hreq   = stop || trap || lim || bp;
      hcause = stop ? 1 : trap ? 2 : lim ? 3 : bp ? 4 : 0;
      exp_en = ((m_state == 1) || (m_state == 2)) && !hreq;
      check("rnd_en", datapathEnable, exp_en);
      check("rnd_state", state, m_state);
      check("rnd_cause", haltCause, m_cause);
      check("rnd_count", retiredCount, m_count);
      if (exp_en && m_count < 64'hFFFF_FFFF) m_count++;
      m_mask = 0;
      case (m_state)
        0: if (start) begin m_state = 1; m_mask = 1; end else if (step) m_state = 2;
        1: if (hreq) begin m_state = 3; m_cause = hcause; end
        2: if (hreq) begin m_state = 3; m_cause = hcause; end else m_state = 0;
        3: if (clearHalt) begin m_state = 0; m_cause = 0; end
        default: m_state = 0;
      endcase
      edge1();
    end
    start = 1'b0; step = 1'b0; clearHalt = 1'b0; stop = 1'b0;

    // 6: 4-bit counter saturation
    s_start = 1'b1; edge1(); s_start = 1'b0;
    repeat (20) edge1();
    check("t6_sat_count", s_count, 4'd15);
    check("t6_sat_state", s_state, 2'd1);
    check("t6_sat_en", s_en, 1'b1);
    check("t6_sat_cause", s_cause, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
